// File: rtl/input_debounce_pkg.sv
// input_debounce_pkg: shared state encoding and default parameters for the debouncer
package input_debounce_pkg;
   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } state_t;
   localparam int DEBOUNCE_DEFAULT = 16;
   localparam int CNT_W_DEFAULT    = 5;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser, hold-count FSM, clean level and edge pulses
// clk/rst   : rising-edge clock, synchronous active-high reset
// raw       : asynchronous input pin
// level     : debounced level
// rise/fall : one-cycle pulses on level transitions
// idle      : channel FSM is in STABLE
module debounce_channel
   import input_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic idle
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic s1, s2, done, level_n;
   state_t st, st_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   // done marks the accept edge; st_n covers both states since a match always returns to STABLE
   always_comb begin
      done    = st == ST_SETTLING && s2 != level && cnt == LAST;
      st_n    = (s2 != level && !done) ? ST_SETTLING : ST_STABLE;
      cnt_n   = st_n == ST_SETTLING ? (st == ST_STABLE ? CNT_W'(1) : cnt + CNT_W'(1)) : '0;
      level_n = done ? s2 : level;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         st    <= ST_STABLE;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         st    <= st_n;
         cnt   <= cnt_n;
         level <= level_n;
         rise  <= done & s2;
         fall  <= done & ~s2;
      end
   end
   assign idle = st == ST_STABLE;
endmodule

// File: rtl/input_debounce.sv
// input_debounce: two independent debounced channels plus a registered both-stable flag
// clk/rst            : rising-edge clock, synchronous active-high reset
// a_raw/b_raw        : asynchronous raw inputs
// a/b                : debounced levels
// a_rise/a_fall etc. : one-cycle transition pulses per channel
// stable             : both channels were in STABLE on the previous cycle
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic a_raw,
   input  logic b_raw,
   output logic a,
   output logic b,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall,
   output logic stable
);
   logic a_idle, b_idle;
   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_a (
      .clk(clk), .rst(rst), .raw(a_raw), .level(a), .rise(a_rise), .fall(a_fall), .idle(a_idle)
   );
   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_b (
      .clk(clk), .rst(rst), .raw(b_raw), .level(b), .rise(b_rise), .fall(b_fall), .idle(b_idle)
   );
   always_ff @(posedge clk) begin
      if (rst) stable <= 1'b1;
      else     stable <= a_idle & b_idle;
   end
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: table-driven and directed checks of input_debounce with DEBOUNCE_CYCLES=4
module tb_input_debounce;
   logic clk = 1'b0, rst = 1'b1, a_raw = 1'b0, b_raw = 1'b0;
   logic a, b, a_rise, a_fall, b_rise, b_fall, stable;
   int tests = 0, fails = 0;

   typedef struct {
      logic       rst, ar, br;
      logic [6:0] exp;
   } vec_t;
   vec_t tbl[$];

   input_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw), .a(a), .b(b),
      .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall), .stable(stable)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [6:0] exp);
      logic [6:0] act;
      act = {a, b, a_rise, a_fall, b_rise, b_fall, stable};
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got {a,b,ar,af,br,bf,st}=%b expected %b", name, idx, act, exp);
      end
   endtask

   // bit n-1-i of each pattern is row i, so patterns read left to right in time
   task automatic scen(input int n, input logic [15:0] rs, ra, rb, ea, eb, ear, eaf, ebr, ebf, est);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         int k;
         k = n - 1 - i;
         v.rst = rs[k];
         v.ar  = ra[k];
         v.br  = rb[k];
         v.exp = {ea[k], eb[k], ear[k], eaf[k], ebr[k], ebf[k], est[k]};
         tbl.push_back(v);
      end
   endtask

   initial begin
      // reset with toggling inputs, then idle
      scen(5, 16'b11100, 16'b10100, 16'b01100, 0, 0, 0, 0, 0, 0, 16'b11111);
      // a rises, b untouched
      scen(8, 0, 16'b11111111, 0, 16'b00000111, 0, 16'b00000100, 0, 0, 0, 16'b11100011);
      // a falls through 2-cycle bounce
      scen(11, 0, 16'b00110000000, 0, 16'b11111111100, 0, 0, 16'b00000000010, 0, 0, 16'b11100110001);
      // 3-sample pulse rejected
      scen(8, 0, 16'b11100000, 0, 0, 0, 0, 0, 0, 0, 16'b11100011);
      // 4-sample pulse accepted, then the return low is accepted too
      scen(11, 0, 16'b11110000000, 0, 16'b00000111100, 0, 16'b00000100000, 16'b00000000010, 0, 0,
           16'b11100010001);
      // both rise together, then both fall together
      scen(8, 0, 16'b11111111, 16'b11111111, 16'b00000111, 16'b00000111, 16'b00000100, 0,
           16'b00000100, 0, 16'b11100011);
      scen(8, 0, 0, 0, 16'b11111000, 16'b11111000, 0, 16'b00000100, 0, 16'b00000100, 16'b11100011);

      foreach (tbl[i]) begin
         rst   = tbl[i].rst;
         a_raw = tbl[i].ar;
         b_raw = tbl[i].br;
         tick();
         chk("vec", i, tbl[i].exp);
      end

      // reset lands mid-settle: no pulse, then a held level is accepted at r+5
      rst   = 1'b0;
      a_raw = 1'b1;
      b_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pre_rst", i, 7'b0000001);
      end
      rst = 1'b1;
      tick();
      chk("mid_rst", 0, 7'b0000001);
      rst = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         tick();
         chk("post_rst", i, {i >= 5, 1'b0, i == 5, 1'b0, 1'b0, 1'b0, i < 3 || i == 6});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
